// File: rtl/ysyx_25060170_seq.sv
// Multi-cycle core sequencer: owns the PC, handshakes with fetch, data memory and writeback.
// Optional bus wait timeout is enabled by defining YSYX_25060170_SEQ_BUS_TIMEOUT_EN.
module ysyx_25060170_seq #(
  parameter int unsigned     XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_PC       = 32'h8000_0000,
  parameter int unsigned     TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req_valid,
  output logic [XLEN-1:0] ifu_req_addr,
  input  logic            ifu_req_ready,
  input  logic            ifu_rsp_valid,
  input  logic [31:0]     ifu_rsp_inst,
  input  logic            ifu_rsp_err,
  output logic [31:0]     inst_o,
  input  logic            is_load_i,
  input  logic            is_store_i,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            halt_i,
  output logic            lsu_req_valid,
  input  logic            lsu_req_ready,
  input  logic            lsu_rsp_valid,
  input  logic            lsu_rsp_err,
  output logic            wb_en_o,
  output logic [XLEN-1:0] pc_o,
  output logic            commit_o,
  output logic            halted_o,
  output logic            fault_o,
  output logic [XLEN-1:0] fault_pc_o
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_EXEC,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_WB,
    S_HALT,
    S_FAULT
  } state_e;

  state_e          state_q,     state_d;
  logic [XLEN-1:0] pc_q,        pc_d;
  logic [31:0]     inst_q,      inst_d;
  logic            jump_en_q,   jump_en_d;
  logic [XLEN-1:0] jump_addr_q, jump_addr_d;
  logic            store_q,     store_d;
  logic [XLEN-1:0] fault_pc_q,  fault_pc_d;

`ifdef YSYX_25060170_SEQ_BUS_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    jump_en_d   = jump_en_q;
    jump_addr_d = jump_addr_q;
    store_d     = store_q;
    fault_pc_d  = fault_pc_q;

    unique case (state_q)
      S_FETCH_REQ: begin
        if (ifu_req_ready) state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        if (ifu_rsp_valid) begin
          if (ifu_rsp_err) begin
            state_d = S_FAULT;
          end else begin
            inst_d  = ifu_rsp_inst;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        jump_en_d   = jump_en_i;
        jump_addr_d = jump_addr_i;
        store_d     = is_store_i;
        if (halt_i)                        state_d = S_HALT;
        else if (is_load_i || is_store_i)  state_d = S_MEM_REQ;
        else                               state_d = S_WB;
      end
      S_MEM_REQ: begin
        if (lsu_req_ready) state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (lsu_rsp_valid) state_d = lsu_rsp_err ? S_FAULT : S_WB;
      end
      S_WB: begin
        pc_d    = jump_en_q ? jump_addr_q : pc_q + XLEN'(4);
        state_d = S_FETCH_REQ;
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH_REQ;
    endcase

`ifdef YSYX_25060170_SEQ_BUS_TIMEOUT_EN
    // Counter only advances while parked in a wait state; a response on the expiry cycle wins.
    tmo_d = '0;
    if ((state_q == S_FETCH_WAIT && !ifu_rsp_valid) ||
        (state_q == S_MEM_WAIT   && !lsu_rsp_valid)) begin
      if (tmo_q == TMO_LAST) state_d = S_FAULT;
      else                   tmo_d   = tmo_q + 1'b1;
    end
`endif

    // PC only moves in WB, so the current PC is the faulting instruction's PC.
    if (state_d == S_FAULT && state_q != S_FAULT) fault_pc_d = pc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_FETCH_REQ;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      jump_en_q   <= 1'b0;
      jump_addr_q <= '0;
      store_q     <= 1'b0;
      fault_pc_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      jump_en_q   <= jump_en_d;
      jump_addr_q <= jump_addr_d;
      store_q     <= store_d;
      fault_pc_q  <= fault_pc_d;
    end
  end

`ifdef YSYX_25060170_SEQ_BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`endif

  assign ifu_req_valid = (state_q == S_FETCH_REQ);
  assign ifu_req_addr  = pc_q;
  assign inst_o        = inst_q;
  assign lsu_req_valid = (state_q == S_MEM_REQ);
  assign commit_o      = (state_q == S_WB);
  assign wb_en_o       = (state_q == S_WB) && !store_q;
  assign pc_o          = pc_q;
  assign halted_o      = (state_q == S_HALT);
  assign fault_o       = (state_q == S_FAULT);
  assign fault_pc_o    = fault_pc_q;

endmodule

// File: tb/tb_ysyx_25060170_seq.sv
// Self-checking bench for ysyx_25060170_seq: the bench acts as fetch/data bus and decoder,
// and tracks PC, latency and outcome per instruction with a transaction-level model.
module tb_ysyx_25060170_seq;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_ready;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_inst;
  logic        ifu_rsp_err;
  logic [31:0] inst_o;
  logic        is_load_i, is_store_i, jump_en_i, halt_i;
  logic [31:0] jump_addr_i;
  logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
  logic        wb_en_o, commit_o, halted_o, fault_o;
  logic [31:0] pc_o, fault_pc_o;

  int unsigned vec_cnt  = 0;
  int unsigned miss_cnt = 0;
  logic [31:0] model_pc;

  always #5 clk = ~clk;

  ysyx_25060170_seq #(
    .XLEN          (32),
    .RESET_PC      (RST_PC),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst          (rst_n),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_addr (ifu_req_addr),
    .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rsp_inst (ifu_rsp_inst),
    .ifu_rsp_err  (ifu_rsp_err),
    .inst_o       (inst_o),
    .is_load_i    (is_load_i),
    .is_store_i   (is_store_i),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .halt_i       (halt_i),
    .lsu_req_valid(lsu_req_valid),
    .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid),
    .lsu_rsp_err  (lsu_rsp_err),
    .wb_en_o      (wb_en_o),
    .pc_o         (pc_o),
    .commit_o     (commit_o),
    .halted_o     (halted_o),
    .fault_o      (fault_o),
    .fault_pc_o   (fault_pc_o)
  );

  task automatic step();
    @(negedge clk);
  endtask

  // Decoder outputs are only meaningful in EXEC; noise elsewhere must be ignored.
  task automatic garbage();
    is_load_i   = 1'($urandom);
    is_store_i  = 1'($urandom);
    jump_en_i   = 1'($urandom);
    halt_i      = 1'($urandom);
    jump_addr_i = $urandom;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_err = 1'b0; ifu_rsp_inst = $urandom;
    lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0; lsu_rsp_err = 1'b0;
    garbage();
    step(); step();
    rst_n = 1'b1;
    model_pc = RST_PC;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++; if (pc_o !== RST_PC) begin miss_cnt++; $display("FAIL reset_pc: got %h expected %h", pc_o, RST_PC); end
    vec_cnt++; if (inst_o !== 32'h0) begin miss_cnt++; $display("FAIL reset_inst: got %h expected 0", inst_o); end
    vec_cnt++; if (fault_pc_o !== 32'h0) begin miss_cnt++; $display("FAIL reset_fault_pc: got %h expected 0", fault_pc_o); end
    vec_cnt++;
    if ({commit_o, wb_en_o, lsu_req_valid, halted_o, fault_o} !== 5'b0) begin
      miss_cnt++; $display("FAIL reset_flags: got %b expected 00000", {commit_o, wb_en_o, lsu_req_valid, halted_o, fault_o});
    end
    apply_reset();
  endtask

  // Checks the terminal FAULT state: sticky flag, captured PC, and no more bus activity.
  task automatic check_fault(input string tag);
    vec_cnt++; if (fault_o !== 1'b1) begin miss_cnt++; $display("FAIL %s_fault: got %b expected 1", tag, fault_o); end
    vec_cnt++; if (fault_pc_o !== model_pc) begin miss_cnt++; $display("FAIL %s_fault_pc: got %h expected %h", tag, fault_pc_o, model_pc); end
    for (int i = 0; i < 4; i++) begin
      ifu_req_ready = 1'b1; lsu_req_ready = 1'b1; garbage();
      step();
      vec_cnt++;
      if ({ifu_req_valid, lsu_req_valid, commit_o, wb_en_o, fault_o} !== 5'b00001) begin
        miss_cnt++; $display("FAIL %s_fault_quiet: got %b expected 00001", tag, {ifu_req_valid, lsu_req_valid, commit_o, wb_en_o, fault_o});
      end
    end
    ifu_req_ready = 1'b0; lsu_req_ready = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] inst, input bit ld, input bit st, input bit jmp,
                           input logic [31:0] jaddr, input int frdy, input int frsp, input bit ferr,
                           input int mrdy, input int mrsp, input bit merr, input bit hlt);
    int cyc, wn, vcnt, exp_lat;
    bit mem;
    logic [31:0] next_pc;
    mem = (ld || st) && !hlt;
    exp_lat = 4 + frdy + frsp + (mem ? 2 + mrdy + mrsp : 0);
    next_pc = jmp ? jaddr : model_pc + 32'd4;

    wn = 0;
    while (!ifu_req_valid && wn < 20) begin step(); wn++; end
    vec_cnt++;
    if (ifu_req_valid !== 1'b1) begin miss_cnt++; $display("FAIL fetch_req_timeout: got %b expected 1", ifu_req_valid); return; end
    vec_cnt++; if (ifu_req_addr !== model_pc) begin miss_cnt++; $display("FAIL fetch_addr: got %h expected %h", ifu_req_addr, model_pc); end

    cyc = 1;
    for (int i = 0; i < frdy; i++) begin
      ifu_req_ready = 1'b0; ifu_rsp_valid = 1'($urandom); ifu_rsp_err = 1'b1; garbage();
      lsu_rsp_valid = 1'($urandom); lsu_rsp_err = 1'b1;
      step(); cyc++;
      vec_cnt++;
      if (ifu_req_valid !== 1'b1 || ifu_req_addr !== model_pc) begin
        miss_cnt++; $display("FAIL fetch_hold: got %b/%h expected 1/%h", ifu_req_valid, ifu_req_addr, model_pc);
      end
    end
    ifu_req_ready = 1'b1; ifu_rsp_valid = 1'($urandom); ifu_rsp_err = 1'b1; garbage();
    step(); cyc++;
    ifu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
    vec_cnt++; if (ifu_req_valid !== 1'b0) begin miss_cnt++; $display("FAIL fetch_wait_req: got %b expected 0", ifu_req_valid); end

    for (int i = 0; i < frsp; i++) begin
      ifu_rsp_valid = 1'b0; ifu_rsp_inst = $urandom; garbage();
      step(); cyc++;
    end
    ifu_rsp_valid = 1'b1; ifu_rsp_err = ferr; ifu_rsp_inst = inst;
    step(); cyc++;
    ifu_rsp_valid = 1'b0; ifu_rsp_err = 1'b0; ifu_rsp_inst = $urandom;
    if (ferr) begin check_fault("fetch"); return; end

    vec_cnt++; if (inst_o !== inst) begin miss_cnt++; $display("FAIL exec_inst: got %h expected %h", inst_o, inst); end
    vec_cnt++; if (commit_o !== 1'b0) begin miss_cnt++; $display("FAIL exec_commit: got %b expected 0", commit_o); end
    is_load_i = ld; is_store_i = st; jump_en_i = jmp; jump_addr_i = jaddr; halt_i = hlt;
    lsu_rsp_valid = 1'b1; lsu_rsp_err = 1'b1;
    step(); cyc++;
    garbage(); lsu_rsp_valid = 1'b0; lsu_rsp_err = 1'b0;

    if (hlt) begin
      for (int i = 0; i < 4; i++) begin
        vec_cnt++;
        if ({halted_o, ifu_req_valid, lsu_req_valid, commit_o} !== 4'b1000 || pc_o !== model_pc) begin
          miss_cnt++; $display("FAIL halt_state: got %b pc %h expected 1000 pc %h", {halted_o, ifu_req_valid, lsu_req_valid, commit_o}, pc_o, model_pc);
        end
        lsu_req_ready = 1'b1; ifu_req_ready = 1'b1; garbage();
        step();
      end
      lsu_req_ready = 1'b0; ifu_req_ready = 1'b0;
      return;
    end

    if (mem) begin
      vcnt = 0;
      for (int i = 0; i < mrdy; i++) begin
        if (lsu_req_valid) vcnt++;
        lsu_req_ready = 1'b0; lsu_rsp_valid = 1'($urandom); lsu_rsp_err = 1'b1; garbage();
        step(); cyc++;
      end
      if (lsu_req_valid) vcnt++;
      lsu_req_ready = 1'b1; lsu_rsp_valid = 1'($urandom); lsu_rsp_err = 1'b1;
      step(); cyc++;
      lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
      for (int i = 0; i < mrsp; i++) begin
        if (lsu_req_valid) vcnt++;
        garbage(); step(); cyc++;
      end
      if (lsu_req_valid) vcnt++;
      lsu_rsp_valid = 1'b1; lsu_rsp_err = merr;
      step(); cyc++;
      lsu_rsp_valid = 1'b0; lsu_rsp_err = 1'b0;
      vec_cnt++; if (vcnt != mrdy + 1) begin miss_cnt++; $display("FAIL lsu_req_cycles: got %0d expected %0d", vcnt, mrdy + 1); end
      if (merr) begin check_fault("mem"); return; end
    end

    vec_cnt++; if (commit_o !== 1'b1) begin miss_cnt++; $display("FAIL wb_commit: got %b expected 1", commit_o); end
    vec_cnt++; if (wb_en_o !== !(mem && st)) begin miss_cnt++; $display("FAIL wb_en: got %b expected %b", wb_en_o, !(mem && st)); end
    vec_cnt++; if (cyc != exp_lat) begin miss_cnt++; $display("FAIL latency: got %0d expected %0d", cyc, exp_lat); end
    step();
    vec_cnt++; if (commit_o !== 1'b0 || wb_en_o !== 1'b0) begin miss_cnt++; $display("FAIL post_wb_strobe: got %b%b expected 00", commit_o, wb_en_o); end
    vec_cnt++; if (pc_o !== next_pc) begin miss_cnt++; $display("FAIL next_pc: got %h expected %h", pc_o, next_pc); end
    model_pc = next_pc;
  endtask

  task automatic test_alu_basic();
    run_instr(32'h0010_0093, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_jump();
    run_instr(32'h1000_006f, 0, 0, 1, 32'h8000_0100, 0, 0, 0, 0, 0, 0, 0);
    run_instr(32'h0000_0013, 0, 0, 0, 32'h0, 1, 2, 0, 0, 0, 0, 0);
  endtask

  task automatic test_load_stall();
    run_instr(32'h0000_2083, 1, 0, 0, 32'h0, 0, 0, 0, 2, 3, 0, 0);
  endtask

  task automatic test_store();
    run_instr(32'h0010_2023, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    run_instr(32'h0000_006f, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0);
    run_instr(32'h0000_0013, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int k;
    for (int n = 0; n < 40; n++) begin
      k = int'($urandom_range(3));
      run_instr($urandom, k == 1, k == 2, (k == 3) || ($urandom_range(7) == 0),
                $urandom & 32'hFFFF_FFFC, int'($urandom_range(3)), int'($urandom_range(3)), 0,
                int'($urandom_range(3)), int'($urandom_range(3)), 0, 0);
    end
  endtask

  task automatic test_halt_load();
    run_instr(32'h0010_0073, 1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 1);
    apply_reset();
  endtask

  task automatic test_fetch_fault();
    apply_reset();
    run_instr(32'h0000_0013, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(32'h0000_0013, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 0);
    vec_cnt++; if (model_pc !== 32'h8000_0008) begin miss_cnt++; $display("FAIL fault_setup_pc: got %h expected 80000008", model_pc); end
    run_instr(32'h0000_0013, 0, 0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++; if (pc_o !== RST_PC || fault_o !== 1'b0) begin miss_cnt++; $display("FAIL async_reset_fault: got pc %h fault %b expected %h 0", pc_o, fault_o, RST_PC); end
    apply_reset();
  endtask

  task automatic test_mem_fault();
    run_instr(32'h0000_0013, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(32'h0000_2083, 1, 0, 0, 32'h0, 0, 0, 0, 1, 2, 1, 0);
    apply_reset();
  endtask

  task automatic test_long_wait();
`ifdef YSYX_25060170_SEQ_BUS_TIMEOUT_EN
    int wn;
    wn = 0;
    while (!ifu_req_valid && wn < 20) begin step(); wn++; end
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    for (int i = 1; i < 16; i++) step();
    vec_cnt++; if (fault_o !== 1'b0) begin miss_cnt++; $display("FAIL timeout_early: got %b expected 0", fault_o); end
    step();
    check_fault("timeout");
    apply_reset();
`else
    run_instr(32'h0000_0013, 0, 0, 0, 32'h0, 0, 40, 0, 0, 0, 0, 0);
    run_instr(32'h0000_2083, 1, 0, 0, 32'h0, 0, 0, 0, 0, 40, 0, 0);
    vec_cnt++; if (fault_o !== 1'b0) begin miss_cnt++; $display("FAIL long_wait_fault: got %b expected 0", fault_o); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vec_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    apply_reset();
    test_reset();
    test_alu_basic();
    test_jump();
    test_load_stall();
    test_store();
    test_wrap();
    test_random();
    test_long_wait();
    test_halt_load();
    test_fetch_fault();
    test_mem_fault();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
